// File: rtl/hamming_rx_deser.sv
// Serial Hamming(31,26) receiver: start-bit detect, 31-bit shift-in, stop check,
// single-error correction and payload extraction with a one-cycle valid strobe.
module hamming_rx_deser #(
    parameter int DATA_W     = 26,
    parameter int CODE_W     = 31,
    parameter int STOP_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Din,
    output logic [DATA_W-1:0] Dout,
    output logic              valid,
    output logic              corrected,
    output logic              frame_err,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;

    state_t              r_state;
    logic [4:0]          r_cnt;
    logic [CODE_W-1:0]   r_sh;     // r_sh[p-1] holds codeword position p
    logic [4:0]          w_syn;
    logic [DATA_W-1:0]   w_data;

    always_comb begin
        w_syn = '0;
        for (int p = 1; p <= CODE_W; p++)
            if (r_sh[p-1]) w_syn = w_syn ^ 5'(p);
    end

    // Data bit j sits at the j-th non-power-of-two position; flip it if the syndrome points there.
    for (genvar p = 1; p <= CODE_W; p++) begin : g_extract
        if ((p & (p - 1)) != 0) begin : g_data
            assign w_data[p-1-$clog2(p+1)] = r_sh[p-1] ^ (w_syn == 5'(p));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sh      <= '0;
            Dout      <= '0;
            valid     <= 1'b0;
            corrected <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Din) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_DATA: begin
                    r_sh  <= {r_sh[CODE_W-2:0], Din};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(CODE_W - 1)) r_state <= S_STOP;
                end
                S_STOP: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    if (STOP_CHECK != 0 && Din) begin
                        frame_err <= 1'b1;
                    end else begin
                        valid     <= 1'b1;
                        Dout      <= w_data;
                        corrected <= (w_syn != 5'd0);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
